// File: rtl/tune_player.sv
// Two-song square-wave sequencer for the piezo buzzer: ROM-driven notes with
// tempo scaling, live duty-cycle volume, pause/resume and an articulation gap.
module tune_player #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int BEAT_HZ = 8,
  parameter int GAP_CYC = CLK_HZ / 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic       loop,
  input  logic       song_sel,
  input  logic [1:0] tempo,
  input  logic [2:0] volume,
  output logic       beep,
  output logic       busy,
  output logic [5:0] note_idx,
  output logic       song_done
);

  localparam int BEAT_CYC = CLK_HZ / BEAT_HZ;
  localparam int NW = $clog2(4 * BEAT_CYC + 1);
  localparam int PW = $clog2(CLK_HZ / 262 + 1);
  localparam int MW = PW + 3;

  localparam logic [3:0] REST = 4'd0;
  localparam logic [3:0] L_A  = 4'd7;
  localparam logic [3:0] L_B  = 4'd8;
  localparam logic [3:0] M_C  = 4'd9;
  localparam logic [3:0] M_D  = 4'd10;
  localparam logic [3:0] M_E  = 4'd11;
  localparam logic [3:0] M_F  = 4'd12;
  localparam logic [3:0] M_G  = 4'd13;
  localparam logic [3:0] M_GS = 4'd14;
  localparam logic [3:0] M_A  = 4'd15;

  typedef enum logic [1:0] {IDLE, PLAY, PAUSED} state_t;

  state_t        state, state_next;
  logic          song_q;
  logic [1:0]    tempo_q;
  logic [5:0]    idx;
  logic [NW-1:0] ncnt;
  logic [PW-1:0] tcnt;

  logic [6:0]    entry;
  logic [3:0]    note;
  logic [1:0]    dur;
  logic          last;
  logic [PW-1:0] per;
  logic [NW-1:0] beat_len;
  logic [NW-1:0] nlen;
  logic          note_end;
  logic          tone_wrap;
  logic          tone_hi;
  logic          gap_ok;
  logic          beep_d;
  logic          done_d;

  // ROM word: {end flag, beats-1, note code}
  function automatic logic [6:0] ent(input logic [3:0] n, input logic [1:0] d, input logic e);
    return {e, d, n};
  endfunction

  function automatic logic [6:0] rom_lookup(input logic s, input logic [5:0] i);
    logic [6:0] w;
    w = ent(REST, 2'd0, 1'b1);
    if (s) begin
      case (i)
        6'd0: w = ent(M_A,  2'd0, 1'b0);
        6'd1: w = ent(M_GS, 2'd0, 1'b0);
        6'd2: w = ent(M_E,  2'd0, 1'b0);
        6'd3: w = ent(M_C,  2'd0, 1'b0);
        6'd4: w = ent(L_A,  2'd0, 1'b0);
        6'd5: w = ent(REST, 2'd0, 1'b0);
        6'd6: w = ent(L_A,  2'd1, 1'b1);
        default: w = ent(REST, 2'd0, 1'b1);
      endcase
    end else begin
      case (i)
        6'd0:  w = ent(M_E,  2'd1, 1'b0);
        6'd1:  w = ent(L_B,  2'd0, 1'b0);
        6'd2:  w = ent(M_C,  2'd0, 1'b0);
        6'd3:  w = ent(M_D,  2'd1, 1'b0);
        6'd4:  w = ent(M_C,  2'd0, 1'b0);
        6'd5:  w = ent(L_B,  2'd0, 1'b0);
        6'd6:  w = ent(L_A,  2'd1, 1'b0);
        6'd7:  w = ent(L_A,  2'd0, 1'b0);
        6'd8:  w = ent(M_C,  2'd0, 1'b0);
        6'd9:  w = ent(M_E,  2'd1, 1'b0);
        6'd10: w = ent(M_D,  2'd0, 1'b0);
        6'd11: w = ent(M_C,  2'd0, 1'b0);
        6'd12: w = ent(L_B,  2'd2, 1'b0);
        6'd13: w = ent(M_C,  2'd0, 1'b0);
        6'd14: w = ent(M_D,  2'd1, 1'b0);
        6'd15: w = ent(M_E,  2'd1, 1'b0);
        6'd16: w = ent(M_C,  2'd1, 1'b0);
        6'd17: w = ent(L_A,  2'd1, 1'b0);
        6'd18: w = ent(L_A,  2'd1, 1'b0);
        6'd19: w = ent(REST, 2'd1, 1'b0);
        6'd20: w = ent(REST, 2'd0, 1'b0);
        6'd21: w = ent(M_D,  2'd2, 1'b0);
        6'd22: w = ent(M_F,  2'd0, 1'b0);
        6'd23: w = ent(M_A,  2'd1, 1'b0);
        6'd24: w = ent(M_G,  2'd0, 1'b0);
        6'd25: w = ent(M_F,  2'd0, 1'b0);
        6'd26: w = ent(M_E,  2'd2, 1'b0);
        6'd27: w = ent(M_C,  2'd0, 1'b0);
        6'd28: w = ent(M_E,  2'd1, 1'b0);
        6'd29: w = ent(M_D,  2'd0, 1'b0);
        6'd30: w = ent(M_C,  2'd0, 1'b0);
        6'd31: w = ent(L_B,  2'd1, 1'b0);
        6'd32: w = ent(L_B,  2'd0, 1'b0);
        6'd33: w = ent(M_C,  2'd0, 1'b0);
        6'd34: w = ent(M_D,  2'd1, 1'b0);
        6'd35: w = ent(M_E,  2'd1, 1'b0);
        6'd36: w = ent(M_C,  2'd1, 1'b0);
        6'd37: w = ent(L_A,  2'd1, 1'b0);
        6'd38: w = ent(L_A,  2'd1, 1'b0);
        6'd39: w = ent(REST, 2'd1, 1'b1);
        default: w = ent(REST, 2'd0, 1'b1);
      endcase
    end
    return w;
  endfunction

  // Pitch periods fold to constants; a rest gets a harmless nonzero period.
  function automatic logic [PW-1:0] per_of(input logic [3:0] n);
    case (n)
      4'd1:  return PW'(CLK_HZ / 262);
      4'd2:  return PW'(CLK_HZ / 294);
      4'd3:  return PW'(CLK_HZ / 330);
      4'd4:  return PW'(CLK_HZ / 349);
      4'd5:  return PW'(CLK_HZ / 392);
      4'd6:  return PW'(CLK_HZ / 415);
      4'd7:  return PW'(CLK_HZ / 440);
      4'd8:  return PW'(CLK_HZ / 494);
      4'd9:  return PW'(CLK_HZ / 523);
      4'd10: return PW'(CLK_HZ / 587);
      4'd11: return PW'(CLK_HZ / 659);
      4'd12: return PW'(CLK_HZ / 698);
      4'd13: return PW'(CLK_HZ / 784);
      4'd14: return PW'(CLK_HZ / 831);
      4'd15: return PW'(CLK_HZ / 880);
      default: return PW'(CLK_HZ / 262);
    endcase
  endfunction

  assign entry    = rom_lookup(song_q, idx);
  assign note     = entry[3:0];
  assign dur      = entry[5:4];
  assign last     = entry[6];
  assign per      = per_of(note);
  assign beat_len = NW'(BEAT_CYC) >> tempo_q;

  always_comb begin
    nlen = beat_len;
    case (dur)
      2'd0: nlen = beat_len;
      2'd1: nlen = beat_len << 1;
      2'd2: nlen = beat_len + (beat_len << 1);
      2'd3: nlen = beat_len << 2;
      default: nlen = beat_len;
    endcase
  end

  assign note_end  = (ncnt == nlen - NW'(1));
  assign tone_wrap = (tcnt == per - PW'(1));
  assign tone_hi   = ({tcnt, 3'b000} < (MW'(per) * MW'(volume)));
  assign gap_ok    = (32'(ncnt) + 32'(GAP_CYC)) < 32'(nlen);

  // Control handshake: start/stop are single-cycle pulses accepted on the
  // clock edge that samples them (stop dominates); pause/loop are levels.
  always_comb begin
    state_next = state;
    done_d     = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) state_next = PLAY;
      end
      PLAY: begin
        if (stop) begin
          state_next = IDLE;
        end else if (note_end && last) begin
          done_d = 1'b1;
          if (!loop)      state_next = IDLE;
          else if (pause) state_next = PAUSED;
        end else if (pause) begin
          state_next = PAUSED;
        end
      end
      PAUSED: begin
        if (stop)        state_next = IDLE;
        else if (!pause) state_next = PLAY;
      end
      default: state_next = IDLE;
    endcase
    beep_d = (state == PLAY) && (state_next == PLAY) && (note != REST) && gap_ok && tone_hi;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      song_q    <= 1'b0;
      tempo_q   <= 2'd0;
      idx       <= 6'd0;
      ncnt      <= '0;
      tcnt      <= '0;
      beep      <= 1'b0;
      song_done <= 1'b0;
    end else begin
      state     <= state_next;
      beep      <= beep_d;
      song_done <= done_d;
      if (state == IDLE) begin
        if (start && !stop) begin
          song_q  <= song_sel;
          tempo_q <= tempo;
          idx     <= 6'd0;
          ncnt    <= '0;
          tcnt    <= '0;
        end
      end else if (state == PLAY && !stop) begin
        // The edge that enters PAUSED still counts as a played cycle.
        if (note_end) begin
          ncnt <= '0;
          tcnt <= '0;
          if (!last)     idx <= idx + 6'd1;
          else if (loop) idx <= 6'd0;
        end else begin
          ncnt <= ncnt + NW'(1);
          tcnt <= tone_wrap ? '0 : tcnt + PW'(1);
        end
      end
    end
  end

  assign busy     = (state != IDLE);
  assign note_idx = idx;

endmodule

// File: tb/tb_tune_player.sv
// Bench for tune_player: a position-in-song reference model predicts every
// output cycle; scenario tasks add targeted checks at song boundaries.
module tb_tune_player;

  localparam int CLK_HZ   = 100_000;
  localparam int BEAT_HZ  = 100;
  localparam int GAP_CYC  = 10;
  localparam int BEAT_CYC = CLK_HZ / BEAT_HZ;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, stop = 1'b0, pause = 1'b0, loop = 1'b0, song_sel = 1'b0;
  logic [1:0] tempo = 2'd0;
  logic [2:0] volume = 3'd0;
  logic       beep, busy, song_done;
  logic [5:0] note_idx;

  tune_player #(.CLK_HZ(CLK_HZ), .BEAT_HZ(BEAT_HZ), .GAP_CYC(GAP_CYC)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause), .loop(loop),
    .song_sel(song_sel), .tempo(tempo), .volume(volume),
    .beep(beep), .busy(busy), .note_idx(note_idx), .song_done(song_done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Songs as note code + beat count; song 0 is only known here up to entry 0.
  int s_note[2][40];
  int s_beats[2][40];
  int s_len[2];

  logic [8:0] exp_q[$];
  logic [8:0] obs_q[$];

  logic       m_beep, m_busy, m_done, m_frozen;
  logic [5:0] m_idx;
  int         m_pos, m_song, m_tempo;

  function automatic int freq_of(int code);
    case (code)
      1: return 262;  2: return 294;  3: return 330;  4: return 349;  5: return 392;
      6: return 415;  7: return 440;  8: return 494;  9: return 523;  10: return 587;
      11: return 659; 12: return 698; 13: return 784; 14: return 831; 15: return 880;
      default: return 262;
    endcase
  endfunction

  function automatic int per_of(int code);
    return CLK_HZ / freq_of(code);
  endfunction

  function automatic int nlen_of(int song, int k, int tmp);
    return s_beats[song][k] * (BEAT_CYC >> tmp);
  endfunction

  function automatic int high_cycles(int per, int vol);
    int n = 0;
    for (int t = 0; t < per; t++) if (8 * t < per * vol) n++;
    return n;
  endfunction

  task automatic init_tables();
    int n1[7] = '{15, 14, 11, 9, 7, 0, 7};
    int b1[7] = '{1, 1, 1, 1, 1, 1, 2};
    for (int i = 0; i < 40; i++) begin
      s_note[0][i] = 0; s_beats[0][i] = 1; s_note[1][i] = 0; s_beats[1][i] = 1;
    end
    s_note[0][0] = 11; s_beats[0][0] = 2; s_len[0] = 40;
    for (int i = 0; i < 7; i++) begin s_note[1][i] = n1[i]; s_beats[1][i] = b1[i]; end
    s_len[1] = 7;
  endtask

  task automatic model_reset();
    m_beep = 0; m_busy = 0; m_done = 0; m_frozen = 0; m_idx = 0; m_pos = 0;
    m_song = 0; m_tempo = 0;
    exp_q.delete(); obs_q.delete();
  endtask

  // One clock: drive inputs, predict outputs after the edge, record both.
  task automatic tick(input bit st, input bit sp, input bit pa, input bit lp);
    int k, rem, nl, per;
    start = st; stop = sp; pause = pa; loop = lp;
    m_done = 0;
    if (!m_busy) begin
      m_beep = 0;
      if (st && !sp) begin
        m_busy = 1; m_frozen = 0; m_pos = 0; m_idx = 0;
        m_song = int'(song_sel); m_tempo = int'(tempo);
      end
    end else if (sp) begin
      m_busy = 0; m_beep = 0;
    end else if (m_frozen) begin
      m_beep = 0;
      if (!pa) m_frozen = 0;
    end else begin
      k = 0; rem = m_pos;
      while (k < s_len[m_song] - 1 && rem >= nlen_of(m_song, k, m_tempo)) begin
        rem -= nlen_of(m_song, k, m_tempo); k++;
      end
      nl  = nlen_of(m_song, k, m_tempo);
      per = per_of(s_note[m_song][k]);
      m_beep = !pa && (s_note[m_song][k] != 0) && (rem < nl - GAP_CYC) &&
               (8 * (rem % per) < per * int'(volume));
      if (rem == nl - 1 && k == s_len[m_song] - 1) begin
        m_done = 1; m_pos = 0;
        if (lp) m_idx = 0;
        else begin m_busy = 0; m_beep = 0; end
      end else begin
        m_pos++;
        if (rem == nl - 1) m_idx = 6'(k + 1);
      end
      if (pa && m_busy) m_frozen = 1;
    end
    exp_q.push_back({m_beep, m_busy, m_done, m_idx});
    @(posedge clk);
    @(negedge clk);
    obs_q.push_back({beep, busy, song_done, note_idx});
  endtask

  task automatic test_reset();
    rst = 0;
    repeat (3) @(negedge clk);
    vectors++; if (beep !== 1'b0) begin miscompares++; $display("FAIL reset_beep got %b want 0", beep); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (note_idx !== 6'd0) begin miscompares++; $display("FAIL reset_idx got %0d want 0", note_idx); end
    vectors++; if (song_done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", song_done); end
    rst = 1;
    model_reset();
    repeat (2) tick(0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      logic [8:0] e, o; e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL reset_idle got %b want %b", o, e); end
    end
  endtask

  task automatic test_song1_play();
    int hi = 0, gap_hi = 0;
    song_sel = 1; tempo = 0; volume = 4;
    tick(1, 0, 0, 0);
    vectors++; if ({busy, beep} !== 2'b10) begin miscompares++; $display("FAIL s1_start busy/beep got %b want 10", {busy, beep}); end
    for (int i = 1; i <= 8005; i++) begin
      tick(0, 0, 0, 0);
      if (i <= 113 && beep) hi++;
      if (i >= 991 && i <= 1000 && beep) gap_hi++;
      if (i == 1) begin vectors++; if (beep !== 1'b1) begin miscompares++; $display("FAIL s1_first_beep got %b want 1", beep); end end
      if (i == 1000) begin vectors++; if (note_idx !== 6'd1) begin miscompares++; $display("FAIL s1_step got %0d want 1", note_idx); end end
      if (i == 7999) begin vectors++; if ({busy, song_done} !== 2'b10) begin miscompares++; $display("FAIL s1_pre_end got %b want 10", {busy, song_done}); end end
      if (i == 8000) begin vectors++; if ({busy, song_done} !== 2'b01) begin miscompares++; $display("FAIL s1_end got %b want 01", {busy, song_done}); end end
    end
    vectors++; if (hi !== high_cycles(113, 4)) begin miscompares++; $display("FAIL s1_duty got %0d want %0d", hi, high_cycles(113, 4)); end
    vectors++; if (gap_hi !== 0) begin miscompares++; $display("FAIL s1_gap got %0d want 0", gap_hi); end
    while (exp_q.size() > 0) begin
      logic [8:0] e, o; e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL s1_cycle got %b want %b", o, e); end
    end
  endtask

  task automatic test_tempo_restart();
    song_sel = 1; tempo = 2; volume = 3'($urandom_range(1, 7));
    tick(1, 0, 0, 0);
    tempo = 0;
    for (int i = 1; i <= 2003; i++) begin
      tick(i == 777, 0, 0, 0);
      if (i == 250) begin vectors++; if (note_idx !== 6'd1) begin miscompares++; $display("FAIL t2_step got %0d want 1", note_idx); end end
      if (i == 2000) begin vectors++; if ({busy, song_done} !== 2'b01) begin miscompares++; $display("FAIL t2_end got %b want 01", {busy, song_done}); end end
    end
    while (exp_q.size() > 0) begin
      logic [8:0] e, o; e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL t2_cycle got %b want %b", o, e); end
    end
  endtask

  task automatic test_loop();
    int rest_hi = 0;
    logic [5:0] held;
    song_sel = 1; tempo = 0; volume = 3'($urandom_range(1, 7));
    tick(1, 0, 0, 1);
    for (int i = 1; i <= 8300; i++) begin
      tick(0, 0, 0, 1);
      if (i >= 5001 && i <= 6000 && beep) rest_hi++;
      if (i == 8000) begin vectors++; if ({busy, song_done, note_idx} !== 8'b11_000000) begin miscompares++; $display("FAIL loop_wrap got %b want 11000000", {busy, song_done, note_idx}); end end
    end
    vectors++; if (rest_hi !== 0) begin miscompares++; $display("FAIL loop_rest got %0d want 0", rest_hi); end
    held = m_idx;
    tick(0, 1, 0, 1);
    tick(0, 0, 0, 0);
    vectors++; if ({busy, note_idx} !== {1'b0, held}) begin miscompares++; $display("FAIL loop_stop got %b want %b", {busy, note_idx}, {1'b0, held}); end
    while (exp_q.size() > 0) begin
      logic [8:0] e, o; e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL loop_cycle got %b want %b", o, e); end
    end
  endtask

  task automatic test_pause();
    int pause_hi = 0;
    song_sel = 1; tempo = 0; volume = 3'($urandom_range(1, 7));
    tick(1, 0, 0, 0);
    for (int i = 1; i <= 8305; i++) begin
      tick(0, 0, (i >= 2400 && i < 2700), 0);
      if (i >= 2400 && i <= 2700 && beep) pause_hi++;
      if (i == 3299) begin vectors++; if (note_idx !== 6'd2) begin miscompares++; $display("FAIL pause_hold got %0d want 2", note_idx); end end
      if (i == 3300) begin vectors++; if (note_idx !== 6'd3) begin miscompares++; $display("FAIL pause_resume got %0d want 3", note_idx); end end
      if (i == 8300) begin vectors++; if (song_done !== 1'b1) begin miscompares++; $display("FAIL pause_end got %b want 1", song_done); end end
    end
    vectors++; if (pause_hi !== 0) begin miscompares++; $display("FAIL pause_silent got %0d want 0", pause_hi); end
    while (exp_q.size() > 0) begin
      logic [8:0] e, o; e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL pause_cycle got %b want %b", o, e); end
    end
  endtask

  task automatic test_random_pause();
    int ps[3], pl[3];
    int done_at = -1, frozen_total = 0;
    bit pa;
    for (int w = 0; w < 3; w++) begin
      ps[w] = 500 + 1000 * w + $urandom_range(0, 300);
      pl[w] = $urandom_range(1, 150);
      frozen_total += pl[w];
    end
    song_sel = 1; tempo = 1; volume = 3'($urandom_range(0, 7));
    tick(1, 0, 0, 0);
    for (int i = 1; i <= 6000 && done_at < 0; i++) begin
      pa = 0;
      for (int w = 0; w < 3; w++) if (i >= ps[w] && i < ps[w] + pl[w]) pa = 1;
      tick(0, 0, pa, 0);
      if (song_done) done_at = i;
    end
    vectors++;
    if (done_at != 4000 + frozen_total) begin
      miscompares++; $display("FAIL rpause_end got %0d want %0d", done_at, 4000 + frozen_total);
    end
    tick(0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      logic [8:0] e, o; e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL rpause_cycle got %b want %b", o, e); end
    end
  endtask

  task automatic test_volume();
    int hi = 0;
    song_sel = 1; tempo = 0; volume = 0;
    tick(1, 0, 0, 0);
    for (int i = 1; i <= 1000; i++) begin tick(0, 0, 0, 0); if (beep) hi++; end
    vectors++; if (hi !== 0) begin miscompares++; $display("FAIL vol0_silent got %0d want 0", hi); end
    tick(0, 1, 0, 0);
    hi = 0; volume = 7;
    tick(1, 0, 0, 0);
    for (int i = 1; i <= 113; i++) begin tick(0, 0, 0, 0); if (beep) hi++; end
    vectors++; if (hi !== high_cycles(113, 7)) begin miscompares++; $display("FAIL vol7_duty got %0d want %0d", hi, high_cycles(113, 7)); end
    for (int i = 114; i <= 3000; i++) begin
      volume = 3'($urandom_range(0, 7));
      tick(0, 0, 0, 0);
    end
    tick(0, 1, 0, 0);
    while (exp_q.size() > 0) begin
      logic [8:0] e, o; e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL vol_cycle got %b want %b", o, e); end
    end
  endtask

  task automatic test_stop_start();
    song_sel = 1; tempo = 0; volume = 5;
    tick(1, 1, 0, 0);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ss_idle got %b want 0", busy); end
    tick(1, 0, 0, 0);
    repeat (1500) tick(0, 0, 0, 0);
    tick(1, 1, 0, 0);
    vectors++; if ({busy, beep, note_idx} !== {2'b00, 6'd1}) begin miscompares++; $display("FAIL ss_play got %b want 00000001", {busy, beep, note_idx}); end
    repeat (3) tick(0, 0, 0, 0);
    vectors++; if ({busy, note_idx} !== {1'b0, 6'd1}) begin miscompares++; $display("FAIL ss_stay got %b want 0000001", {busy, note_idx}); end
    while (exp_q.size() > 0) begin
      logic [8:0] e, o; e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL ss_cycle got %b want %b", o, e); end
    end
  endtask

  task automatic test_reset_mid();
    song_sel = 1; tempo = 0; volume = 7;
    tick(1, 0, 0, 0);
    repeat (1030) tick(0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      logic [8:0] e, o; e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL rmid_cycle got %b want %b", o, e); end
    end
    #2 rst = 0;
    #1;
    vectors++;
    if ({beep, busy, song_done, note_idx} !== 9'd0) begin
      miscompares++; $display("FAIL rmid_async got %b want 000000000", {beep, busy, song_done, note_idx});
    end
    @(negedge clk);
    rst = 1;
    model_reset();
    repeat (3) tick(0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      logic [8:0] e, o; e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL rmid_after got %b want %b", o, e); end
    end
  endtask

  task automatic test_song0();
    int hi = 0;
    int v;
    song_sel = 0; tempo = 0; v = $urandom_range(1, 7); volume = 3'(v);
    tick(1, 0, 0, 0);
    for (int i = 1; i <= 2000; i++) begin
      tick(0, 0, 0, 0);
      if (i <= 151 && beep) hi++;
      if (i == 1999) begin vectors++; if (note_idx !== 6'd0) begin miscompares++; $display("FAIL s0_len got %0d want 0", note_idx); end end
    end
    vectors++; if (note_idx !== 6'd1) begin miscompares++; $display("FAIL s0_step got %0d want 1", note_idx); end
    vectors++; if (hi !== high_cycles(per_of(11), v)) begin miscompares++; $display("FAIL s0_duty got %0d want %0d", hi, high_cycles(per_of(11), v)); end
    tick(0, 1, 0, 0);
    while (exp_q.size() > 0) begin
      logic [8:0] e, o; e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL s0_cycle got %b want %b", o, e); end
    end
  endtask

  initial begin
    init_tables();
    model_reset();
    test_reset();
    test_song1_play();
    test_tempo_restart();
    test_loop();
    test_pause();
    test_random_pause();
    test_volume();
    test_stop_start();
    test_reset_mid();
    test_song0();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
